// File: rtl/l2_mshr_alloc_pkg.sv
// l2_mshr_alloc_pkg: shared FSM type and requester index constants for the L2 MSHR allocator.
// N_MSHR / MSHR_BITS normally come from spandex_consts; the defaults below apply only
// when those macros have not already been defined.

`ifndef N_MSHR
`define N_MSHR 4
`endif
`ifndef MSHR_BITS
`define MSHR_BITS 2
`endif

package l2_mshr_alloc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } l2_mshr_alloc_state_t;

    localparam int REQ_CPU   = 0;
    localparam int REQ_EVICT = 1;

endpackage

// File: rtl/l2_mshr_pick.sv
// l2_mshr_pick: combinational lowest-index finder over the free bitmap.

module l2_mshr_pick
    import l2_mshr_alloc_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] i_free_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any_free
);

    // Scan downwards so the last hit left standing is the lowest set bit.
    always_comb begin
        o_idx      = '0;
        o_any_free = |i_free_vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_free_vec[i]) begin
                o_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/l2_mshr_alloc.sv
// l2_mshr_alloc: MSHR entry allocator with two round-robin requesters (CPU, eviction),
// release handling, eviction-stall flag and a flush/drain FSM.
// Optional build macro: L2_MSHR_RESERVE_EN keeps the last free entry for the eviction path.

`ifndef N_MSHR
`define N_MSHR 4
`endif
`ifndef MSHR_BITS
`define MSHR_BITS 2
`endif

module l2_mshr_alloc
    import l2_mshr_alloc_pkg::*;
#(
    parameter int unsigned N_MSHR    = `N_MSHR,
    parameter int unsigned MSHR_BITS = `MSHR_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_alloc_valid,
    output logic [1:0]           o_alloc_ready,
    output logic [MSHR_BITS-1:0] o_alloc_idx,
    input  logic                 i_rel_valid,
    input  logic [MSHR_BITS-1:0] i_rel_idx,
    input  logic                 i_flush_req,
    output logic                 o_flush_done,
    output logic [MSHR_BITS:0]   o_mshr_cnt,
    output logic                 o_mshr_full,
    output logic                 o_evict_stall
);

    localparam int unsigned         MSHR_BITS_P1 = MSHR_BITS + 1;
    localparam logic [MSHR_BITS:0]  CNT_MAX      = MSHR_BITS_P1'(N_MSHR);
    localparam logic [MSHR_BITS:0]  CNT_ONE      = MSHR_BITS_P1'(1);

    logic [N_MSHR-1:0]     r_free_vec;
    logic [MSHR_BITS:0]    r_cnt;
    logic                  r_rr;
    logic                  r_evict_stall;
    logic                  r_flush_done;
    l2_mshr_alloc_state_t  r_state;

    logic [MSHR_BITS-1:0]  w_pick_idx;
    logic                  w_any_free;
    logic                  w_run;
    logic [1:0]            w_elig;
    logic [1:0]            w_grant;
    logic                  w_rel_ok;
    logic [N_MSHR-1:0]     w_free_nxt;
    logic [MSHR_BITS:0]    w_cnt_nxt;

    l2_mshr_pick #(
        .N (N_MSHR),
        .W (MSHR_BITS)
    ) u_pick (
        .i_free_vec (r_free_vec),
        .o_idx      (w_pick_idx),
        .o_any_free (w_any_free)
    );

    assign w_run    = (r_state == RUN);
    // A release only counts when the entry is actually busy.
    assign w_rel_ok = i_rel_valid & ~r_free_vec[i_rel_idx];

    // Eligibility and round-robin arbitration; grant is same-cycle combinational.
    always_comb begin
        w_elig            = '0;
        w_grant           = '0;
        w_elig[REQ_CPU]   = i_alloc_valid[REQ_CPU] & w_any_free & w_run;
`ifdef L2_MSHR_RESERVE_EN
        w_elig[REQ_CPU]   = w_elig[REQ_CPU] & (r_cnt > CNT_ONE);
`endif
        w_elig[REQ_EVICT] = i_alloc_valid[REQ_EVICT] & w_any_free & w_run;
        if (&w_elig) begin
            w_grant = r_rr ? 2'b10 : 2'b01;
        end else begin
            w_grant = w_elig;
        end
    end

    // Next free bitmap and count; grant and release never touch the same bit.
    always_comb begin
        w_free_nxt = r_free_vec;
        if (|w_grant) begin
            w_free_nxt[w_pick_idx] = 1'b0;
        end
        if (w_rel_ok) begin
            w_free_nxt[i_rel_idx] = 1'b1;
        end
        w_cnt_nxt = r_cnt;
        case ({|w_grant, w_rel_ok})
            2'b10:   w_cnt_nxt = r_cnt - CNT_ONE;
            2'b01:   w_cnt_nxt = r_cnt + CNT_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Datapath state: free bitmap, free count, round-robin pointer, eviction stall.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_free_vec    <= '1;
            r_cnt         <= CNT_MAX;
            r_rr          <= 1'b0;
            r_evict_stall <= 1'b0;
        end else begin
            r_free_vec <= w_free_nxt;
            r_cnt      <= w_cnt_nxt;
            // Pointer goes to whoever did not win this grant.
            if (|w_grant) begin
                r_rr <= w_grant[REQ_CPU];
            end
            if (w_rel_ok) begin
                r_evict_stall <= 1'b0;
            end else if (i_alloc_valid[REQ_EVICT] & ~w_grant[REQ_EVICT] & o_mshr_full) begin
                r_evict_stall <= 1'b1;
            end
        end
    end

    // Flush FSM with registered flush_done pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= RUN;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            unique case (r_state)
                RUN: begin
                    if (i_flush_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_cnt == CNT_MAX) begin
                        r_state      <= DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign o_alloc_ready = w_grant;
    assign o_alloc_idx   = w_pick_idx;
    assign o_mshr_cnt    = r_cnt;
    assign o_mshr_full   = (r_cnt == '0);
    assign o_evict_stall = r_evict_stall;
    assign o_flush_done  = r_flush_done;

endmodule
